// File: rtl/rst_seq_pkg.sv
// Shared definitions for the reset sequencer and the diagnostic LED block.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    STAGE     = 2'd2,
    RUN       = 2'd3
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rst_seq_if.sv
// Bundle of the sequencer's lock/request inputs and staged reset outputs.
interface rst_seq_if
  import rst_seq_pkg::*;
#(
  parameter int CNT_W = 8
) ();

  logic             clk_ok;
  logic             rst_req;
  logic             rst_per_n;
  logic             rst_cpu_n;
  logic             ready;
  logic [CNT_W-1:0] lock_loss_cnt;
  state_t           state;

  modport master (
    output clk_ok, rst_req,
    input  rst_per_n, rst_cpu_n, ready, lock_loss_cnt, state
  );

  modport slave (
    input  clk_ok, rst_req,
    output rst_per_n, rst_cpu_n, ready, lock_loss_cnt, state
  );

endinterface

// File: rtl/rst_seq_sync_bit.sv
// Multi-stage flip-flop synchroniser for a single asynchronous bit.
// Clears to 0 so an unknown input reads as "not asserted" after reset.
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  // Shift the asynchronous input through the synchroniser chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/rst_seq.sv
// Staged reset sequencer: waits for a stable PLL lock, releases the
// peripheral reset, then the CPU reset, and counts lock losses.
module rst_seq
  import rst_seq_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_HOLD   = 1024,
  parameter int STAGE_GAP   = 16,
  parameter int CNT_W       = 8
) (
  input  logic     clk,
  input  logic     rst_n,
  rst_seq_if.slave bus
);

  localparam int CW = $clog2(max_int(LOCK_HOLD, STAGE_GAP) + 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(LOCK_HOLD - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(STAGE_GAP - 1);

  logic             w_lock_s;
  logic             w_lock_lost;
  state_t           w_next_state;
  logic [CW-1:0]    w_next_cnt;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_rst_per_n;
  logic             r_rst_cpu_n;
  logic             r_ready;
  logic [CNT_W-1:0] r_loss_cnt;

  sync_bit #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (bus.clk_ok),
    .o_q   (w_lock_s)
  );

  // Next state and counter; lock loss takes priority over a reset request
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_lock_lost  = 1'b0;
    case (r_state)
      WAIT_LOCK: begin
        w_next_cnt = '0;
        if (w_lock_s) begin
          w_next_state = HOLD;
        end
      end
      HOLD: begin
        if (!w_lock_s) begin
          w_next_state = WAIT_LOCK;
          w_next_cnt   = '0;
          w_lock_lost  = 1'b1;
        end else if (bus.rst_req) begin
          w_next_cnt = '0;
        end else if (r_cnt == HOLD_LAST) begin
          w_next_state = STAGE;
          w_next_cnt   = '0;
        end else begin
          w_next_cnt = r_cnt + 1'b1;
        end
      end
      STAGE: begin
        if (!w_lock_s) begin
          w_next_state = WAIT_LOCK;
          w_next_cnt   = '0;
          w_lock_lost  = 1'b1;
        end else if (bus.rst_req) begin
          w_next_state = HOLD;
          w_next_cnt   = '0;
        end else if (r_cnt == GAP_LAST) begin
          w_next_state = RUN;
          w_next_cnt   = '0;
        end else begin
          w_next_cnt = r_cnt + 1'b1;
        end
      end
      RUN: begin
        if (!w_lock_s) begin
          w_next_state = WAIT_LOCK;
          w_next_cnt   = '0;
          w_lock_lost  = 1'b1;
        end else if (bus.rst_req) begin
          w_next_state = HOLD;
          w_next_cnt   = '0;
        end
      end
      default: begin
        w_next_state = WAIT_LOCK;
        w_next_cnt   = '0;
      end
    endcase
  end

  // Register state, counter, decoded outputs and the saturating loss count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= WAIT_LOCK;
      r_cnt       <= '0;
      r_rst_per_n <= 1'b0;
      r_rst_cpu_n <= 1'b0;
      r_ready     <= 1'b0;
      r_loss_cnt  <= '0;
    end else begin
      r_state     <= w_next_state;
      r_cnt       <= w_next_cnt;
      r_rst_per_n <= (w_next_state == STAGE) || (w_next_state == RUN);
      r_rst_cpu_n <= (w_next_state == RUN);
      r_ready     <= (w_next_state == RUN);
      if (w_lock_lost && (r_loss_cnt != {CNT_W{1'b1}})) begin
        r_loss_cnt <= r_loss_cnt + 1'b1;
      end
    end
  end

  assign bus.state         = r_state;
  assign bus.rst_per_n     = r_rst_per_n;
  assign bus.rst_cpu_n     = r_rst_cpu_n;
  assign bus.ready         = r_ready;
  assign bus.lock_loss_cnt = r_loss_cnt;

endmodule

// File: tb/tb_rst_seq.sv
// Directed testbench for the staged reset sequencer (short hold/gap settings).
module tb_rst_seq;
  import rst_seq_pkg::*;

  localparam int SS = 2;
  localparam int LH = 8;
  localparam int SG = 4;
  localparam int CW = 2;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  int   expLoss = 0;

  always #5 clk = ~clk;

  rst_seq_if #(.CNT_W(CW)) bus ();

  rst_seq #(
    .SYNC_STAGES (SS),
    .LOCK_HOLD   (LH),
    .STAGE_GAP   (SG),
    .CNT_W       (CW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Advance n rising edges and settle just after the last one
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Expected state e edges after clk_ok rises with a cleared synchroniser
  function automatic state_t expSeq(input int e);
    if (e <= SS)                return WAIT_LOCK;
    else if (e <= SS + LH)      return HOLD;
    else if (e <= SS + LH + SG) return STAGE;
    else                        return RUN;
  endfunction

  // Pack expected {state, rst_per_n, rst_cpu_n, ready} for a given state
  function automatic logic [4:0] expVec(input state_t st);
    return {st, (st == STAGE) || (st == RUN), st == RUN, st == RUN};
  endfunction

  task automatic doReset();
    rst_n       = 1'b0;
    bus.clk_ok  = 1'b0;
    bus.rst_req = 1'b0;
    tick(3);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [4:0] got;
    rst_n       = 1'b0;
    bus.clk_ok  = 1'b0;
    bus.rst_req = 1'b0;
    tick(2);
    got = {bus.state, bus.rst_per_n, bus.rst_cpu_n, bus.ready};
    checks++;
    if (got !== 5'b0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %b expected %b", got, 5'b0);
    end
    checks++;
    if (bus.lock_loss_cnt !== 2'd0) begin
      errors++;
      $display("[TB] FAIL reset_loss_cnt: got %0d expected 0", bus.lock_loss_cnt);
    end
    rst_n = 1'b1;
    tick(3);
    checks++;
    if (bus.state !== WAIT_LOCK) begin
      errors++;
      $display("[TB] FAIL reset_no_lock_stays: got %0d expected 0", bus.state);
    end
  endtask

  task automatic test_power_up();
    logic [4:0] got;
    doReset();
    bus.clk_ok = 1'b1;
    for (int e = 1; e <= 16; e++) begin
      tick(1);
      got = {bus.state, bus.rst_per_n, bus.rst_cpu_n, bus.ready};
      checks++;
      if (got !== expVec(expSeq(e))) begin
        errors++;
        $display("[TB] FAIL powerup_edge%0d: got %b expected %b", e, got, expVec(expSeq(e)));
      end
    end
    checks++;
    if (bus.lock_loss_cnt !== 2'd0) begin
      errors++;
      $display("[TB] FAIL powerup_loss_cnt: got %0d expected 0", bus.lock_loss_cnt);
    end
  endtask

  task automatic test_unstable_lock();
    logic [4:0] got;
    state_t     st;
    doReset();
    bus.clk_ok = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick(1);
      if (e == 5) bus.clk_ok = 1'b0;
      st  = (e <= 2) ? WAIT_LOCK : ((e <= 7) ? HOLD : WAIT_LOCK);
      got = {bus.state, bus.rst_per_n, bus.rst_cpu_n, bus.ready};
      checks++;
      if (got !== expVec(st)) begin
        errors++;
        $display("[TB] FAIL unstable_edge%0d: got %b expected %b", e, got, expVec(st));
      end
    end
    checks++;
    if (bus.lock_loss_cnt !== 2'd1) begin
      errors++;
      $display("[TB] FAIL unstable_loss_cnt: got %0d expected 1", bus.lock_loss_cnt);
    end
    bus.clk_ok = 1'b1;
    for (int e = 1; e <= 15; e++) begin
      tick(1);
      got = {bus.state, bus.rst_per_n, bus.rst_cpu_n, bus.ready};
      checks++;
      if (got !== expVec(expSeq(e))) begin
        errors++;
        $display("[TB] FAIL unstable_relock_edge%0d: got %b expected %b", e, got, expVec(expSeq(e)));
      end
    end
  endtask

  task automatic test_lock_loss_run();
    logic [4:0] got;
    state_t     st;
    doReset();
    expLoss    = 0;
    bus.clk_ok = 1'b1;
    tick(15);
    checks++;
    if (bus.state !== RUN) begin
      errors++;
      $display("[TB] FAIL lossrun_start: got %0d expected 3", bus.state);
    end
    bus.clk_ok = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      tick(1);
      st  = (e < 3) ? RUN : WAIT_LOCK;
      got = {bus.state, bus.rst_per_n, bus.rst_cpu_n, bus.ready};
      checks++;
      if (got !== expVec(st)) begin
        errors++;
        $display("[TB] FAIL lossrun_edge%0d: got %b expected %b", e, got, expVec(st));
      end
    end
    expLoss = 1;
    checks++;
    if (bus.lock_loss_cnt !== 2'(expLoss)) begin
      errors++;
      $display("[TB] FAIL lossrun_loss_cnt: got %0d expected %0d", bus.lock_loss_cnt, expLoss);
    end
    bus.clk_ok = 1'b1;
    for (int e = 1; e <= 15; e++) begin
      tick(1);
      got = {bus.state, bus.rst_per_n, bus.rst_cpu_n, bus.ready};
      checks++;
      if (got !== expVec(expSeq(e))) begin
        errors++;
        $display("[TB] FAIL lossrun_relock_edge%0d: got %b expected %b", e, got, expVec(expSeq(e)));
      end
    end
  endtask

  task automatic test_rst_req_run();
    logic [4:0] got;
    bus.rst_req = 1'b1;
    tick(1);
    bus.rst_req = 1'b0;
    got = {bus.state, bus.rst_per_n, bus.rst_cpu_n, bus.ready};
    checks++;
    if (got !== expVec(HOLD)) begin
      errors++;
      $display("[TB] FAIL reqrun_hold: got %b expected %b", got, expVec(HOLD));
    end
    for (int e = 1; e <= 12; e++) begin
      tick(1);
      got = {bus.state, bus.rst_per_n, bus.rst_cpu_n, bus.ready};
      checks++;
      if (got !== expVec(expSeq(e + 3))) begin
        errors++;
        $display("[TB] FAIL reqrun_edge%0d: got %b expected %b", e, got, expVec(expSeq(e + 3)));
      end
    end
    checks++;
    if (bus.lock_loss_cnt !== 2'(expLoss)) begin
      errors++;
      $display("[TB] FAIL reqrun_loss_cnt: got %0d expected %0d", bus.lock_loss_cnt, expLoss);
    end
  endtask

  task automatic test_rst_req_stage();
    logic [4:0] got;
    bus.rst_req = 1'b1;
    tick(1);
    bus.rst_req = 1'b0;
    tick(9);
    got = {bus.state, bus.rst_per_n, bus.rst_cpu_n, bus.ready};
    checks++;
    if (got !== expVec(STAGE)) begin
      errors++;
      $display("[TB] FAIL reqstage_in_stage: got %b expected %b", got, expVec(STAGE));
    end
    bus.rst_req = 1'b1;
    tick(1);
    bus.rst_req = 1'b0;
    got = {bus.state, bus.rst_per_n, bus.rst_cpu_n, bus.ready};
    checks++;
    if (got !== expVec(HOLD)) begin
      errors++;
      $display("[TB] FAIL reqstage_hold: got %b expected %b", got, expVec(HOLD));
    end
    for (int e = 1; e <= 12; e++) begin
      tick(1);
      got = {bus.state, bus.rst_per_n, bus.rst_cpu_n, bus.ready};
      checks++;
      if (got !== expVec(expSeq(e + 3))) begin
        errors++;
        $display("[TB] FAIL reqstage_edge%0d: got %b expected %b", e, got, expVec(expSeq(e + 3)));
      end
    end
    checks++;
    if (bus.lock_loss_cnt !== 2'(expLoss)) begin
      errors++;
      $display("[TB] FAIL reqstage_loss_cnt: got %0d expected %0d", bus.lock_loss_cnt, expLoss);
    end
  endtask

  task automatic test_simultaneous();
    logic [4:0] got;
    bus.clk_ok = 1'b0;
    tick(2);
    checks++;
    if (bus.state !== RUN) begin
      errors++;
      $display("[TB] FAIL simul_pre: got %0d expected 3", bus.state);
    end
    bus.rst_req = 1'b1;
    tick(1);
    bus.rst_req = 1'b0;
    got = {bus.state, bus.rst_per_n, bus.rst_cpu_n, bus.ready};
    checks++;
    if (got !== expVec(WAIT_LOCK)) begin
      errors++;
      $display("[TB] FAIL simul_wait: got %b expected %b", got, expVec(WAIT_LOCK));
    end
    expLoss = 2;
    tick(3);
    checks++;
    if (bus.lock_loss_cnt !== 2'(expLoss)) begin
      errors++;
      $display("[TB] FAIL simul_loss_cnt: got %0d expected %0d", bus.lock_loss_cnt, expLoss);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 4; i++) begin
      bus.clk_ok = 1'b1;
      tick(4);
      checks++;
      if (bus.state !== HOLD) begin
        errors++;
        $display("[TB] FAIL sat%0d_hold: got %0d expected 1", i, bus.state);
      end
      bus.clk_ok = 1'b0;
      tick(3);
      checks++;
      if (bus.state !== WAIT_LOCK) begin
        errors++;
        $display("[TB] FAIL sat%0d_wait: got %0d expected 0", i, bus.state);
      end
      expLoss = (expLoss < 3) ? expLoss + 1 : 3;
      checks++;
      if (bus.lock_loss_cnt !== 2'(expLoss)) begin
        errors++;
        $display("[TB] FAIL sat%0d_loss_cnt: got %0d expected %0d", i, bus.lock_loss_cnt, expLoss);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [4:0] got;
    bus.clk_ok = 1'b1;
    tick(6);
    checks++;
    if (bus.state !== HOLD) begin
      errors++;
      $display("[TB] FAIL async_pre_hold: got %0d expected 1", bus.state);
    end
    #3;
    rst_n = 1'b0;
    #1;
    got = {bus.state, bus.rst_per_n, bus.rst_cpu_n, bus.ready};
    checks++;
    if (got !== 5'b0) begin
      errors++;
      $display("[TB] FAIL async_outputs: got %b expected %b", got, 5'b0);
    end
    checks++;
    if (bus.lock_loss_cnt !== 2'd0) begin
      errors++;
      $display("[TB] FAIL async_loss_cnt: got %0d expected 0", bus.lock_loss_cnt);
    end
    tick(2);
    checks++;
    if (bus.state !== WAIT_LOCK) begin
      errors++;
      $display("[TB] FAIL async_held: got %0d expected 0", bus.state);
    end
    rst_n = 1'b1;
    tick(2);
  endtask

  initial begin
    rst_n       = 1'b0;
    bus.clk_ok  = 1'b0;
    bus.rst_req = 1'b0;
    test_reset();
    test_power_up();
    test_unstable_lock();
    test_lock_loss_run();
    test_rst_req_run();
    test_rst_req_stage();
    test_simultaneous();
    test_saturation();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
